tone_osc: RTL and testbench
===========================

Name: tone_osc

Overview:
- Tone/noise oscillator stage that sits directly downstream of the frqdivmod clock divider.
- Consumes the divider output (s_out) as its step enable, counts a programmable note period in steps, and emits a 12-bit audio sample word for the mixer/DAC path.
- Supports glitch-free period updates at cycle boundaries and square, pulse or 1-bit noise waveforms.

Parameters:
- PERIOD_W, 8, width of the period and step counter.
- OUT_W, 12, sample width; MIDSCALE = 1 << (OUT_W-1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  step source from frqdivmod s_out; may be a strobe or a square wave; only rising edges count.
- period_in  in  PERIOD_W  requested note period, in steps.
- period_wr  in  1  one-clk write strobe for period_in.
- wave_sel  in  2  0 = square 50%, 1 = pulse 25%, 2 = noise, 3 = off.
- gate  in  1  1 = sound, 0 = output forced to MIDSCALE; counter keeps running.
- out  out  OUT_W  registered sample.
- cycle_start  out  1  one-clk pulse on each period wrap.
- period_busy  out  1  a written period is pending and not yet applied.

Behaviour:
- Reset values:
  - Internal state: tick_r=0, cnt=0, period_act=0, pending=0, lfsr=15'h0001.
  - Outputs: period_busy=0, cycle_start=0, out=MIDSCALE (0x800).
- Step detection: step = tick & ~tick_r; tick_r registered every clk. A tick held high counts exactly once.
- Period write:
  - If period_act==0: period_in loads directly into period_act, cnt<=0, busy stays 0.
  - Otherwise period_in goes to pending and period_busy<=1.
  - Multiple writes before a wrap: last write wins.
- Counting:
  - On step with period_act!=0: if cnt==period_act-1, wrap.
  - Wrap actions: cnt<=0, cycle_start<=1, lfsr advances, and period_act<=pending if busy, then busy<=0.
  - Otherwise cnt<=cnt+1.
- Simultaneous period_wr and wrap: the newly written value is applied at that wrap, and busy ends 0.
- period_act==0:
  - Counter is frozen at 0, no cycle_start pulses, out=MIDSCALE.
  - Writing 0 while running takes effect at the next wrap, after which the oscillator is silent.
- Level bit h, evaluated on the next-state cnt and lfsr:
  - Square: h = cnt < ((period_act+1)>>1). Period 1 is always high; period 5 is high for 3 steps.
  - Pulse: h = cnt < max(1, period_act>>2).
  - Noise: h = lfsr[0].
- LFSR: 15-bit, next = {lfsr[13:0], lfsr[14]^lfsr[13]}; advances only on wrap.
- Output:
  - Registered; updates 1 clk after the step edge, in the same cycle cnt changes.
  - out = (gate && wave_sel!=3 && period_act!=0) ? (h ? all-ones : 0) : MIDSCALE.
- rst mid-cycle returns all state to the reset values on the next clk, regardless of tick or period_wr.

Optional Feature:
- Macro: TONE_OSC_VOLUME_EN.
- Defined:
  - Adds port vol, in, 4 bits.
  - High level = MIDSCALE + (vol<<7); low level = MIDSCALE - (vol<<7). vol=15 gives 0xF80/0x080.
  - vol=0 gives constant MIDSCALE.
  - vol is sampled combinationally into the registered out.
- Undefined: no vol port; full swing 0xFFF/0x000.

Decomposition:
- Package tone_osc_pkg:
  - Wave-select constants WAVE_SQUARE, WAVE_PULSE, WAVE_NOISE, WAVE_OFF.
  - MIDSCALE, LFSR_SEED=15'h0001, LFSR width 15.
- Natural sub-module: lfsr15 (clk, rst, adv, state[14:0]), instantiated once.

Test Plan:
- Reset: assert rst 2 clks with tick toggling -> out=0x800, cycle_start=0, period_busy=0, no steps counted.
- Square: period_wr 4, wave 0, gate 1, tick = 1-clk strobe every 3 clks -> out per step FFF,FFF,000,000 repeating; cycle_start every 4th step.
- Edge detect: tick held high 10 clks, then low -> exactly 1 step counted (cnt 0->1).
- Period change: running at period 4, write 6 at cnt=1 -> busy=1, remaining old steps complete, wrap applies 6, busy=0, next cycle is 3 high + 3 low steps.
- Noise: period 1, wave 2 -> wraps 1..13 give out=000, wrap 14 gives lfsr=0x4001 and out=FFF, wrap 15 gives lfsr=0x0003.
- Mid-operation: gate 0 -> out=0x800 while cycle_start keeps pulsing; rst during cnt=2 -> period_act=0 and out=0x800 next clk.

Source files
------------

// File: rtl/tone_osc_pkg.sv
// Shared constants and the LFSR step function for the tone/noise oscillator.
// Build option TONE_OSC_VOLUME_EN adds a 4-bit volume input (see tone_osc.sv).
package tone_osc_pkg;

  localparam logic [1:0] WAVE_SQUARE = 2'd0;
  localparam logic [1:0] WAVE_PULSE  = 2'd1;
  localparam logic [1:0] WAVE_NOISE  = 2'd2;
  localparam logic [1:0] WAVE_OFF    = 2'd3;

  localparam int              OUT_W_DEF = 12;
  localparam logic [11:0]     MIDSCALE  = 12'h800;

  localparam int              LFSR_W    = 15;
  localparam logic [14:0]     LFSR_SEED = 15'h0001;

  // x^15 + x^14 + 1, shifted left with the feedback entering at bit 0
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[LFSR_W-1] ^ s[LFSR_W-2]};
  endfunction

endpackage

// File: rtl/tone_osc_if.sv
// Control/sample bus between the oscillator and its driver.
// With TONE_OSC_VOLUME_EN defined the bus also carries the 4-bit vol input.
interface tone_osc_if #(
  parameter int PERIOD_W = 8,
  parameter int OUT_W    = 12
);

  logic                tick;
  logic [PERIOD_W-1:0] period_in;
  logic                period_wr;
  logic [1:0]          wave_sel;
  logic                gate;
`ifdef TONE_OSC_VOLUME_EN
  logic [3:0]          vol;
`endif
  logic [OUT_W-1:0]    out;
  logic                cycle_start;
  logic                period_busy;

  modport master (
`ifdef TONE_OSC_VOLUME_EN
    output vol,
`endif
    output tick,
    output period_in,
    output period_wr,
    output wave_sel,
    output gate,
    input  out,
    input  cycle_start,
    input  period_busy
  );

  modport slave (
`ifdef TONE_OSC_VOLUME_EN
    input  vol,
`endif
    input  tick,
    input  period_in,
    input  period_wr,
    input  wave_sel,
    input  gate,
    output out,
    output cycle_start,
    output period_busy
  );

endinterface

// File: rtl/tone_osc_lfsr15.sv
// 15-bit noise LFSR; advances one position per adv pulse.
// Unaffected by TONE_OSC_VOLUME_EN.
module tone_osc_lfsr15
  import tone_osc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LFSR_SEED;
    end else if (adv) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/tone_osc.sv
// Tone/noise oscillator: counts note periods in divider steps and emits a 12-bit sample.
// Define TONE_OSC_VOLUME_EN to scale the swing by a 4-bit vol input on the bus.
module tone_osc
  import tone_osc_pkg::*;
#(
  parameter int PERIOD_W = 8,
  parameter int OUT_W    = 12
) (
  input logic       clk,
  input logic       rst,
  tone_osc_if.slave bus
);

  localparam logic [PERIOD_W-1:0] P_ONE = PERIOD_W'(1);
  localparam logic [PERIOD_W:0]   T_ONE = (PERIOD_W+1)'(1);
  localparam logic [OUT_W-1:0]    MID   = OUT_W'(1) << (OUT_W-1);

  logic                tick_r;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] period_act;
  logic [PERIOD_W-1:0] pending;
  logic                busy;
  logic [LFSR_W-1:0]   lfsr_q;

  logic                step;
  logic                running;
  logic                wrap;
  logic [PERIOD_W-1:0] cnt_nx;
  logic [PERIOD_W-1:0] act_nx;
  logic [PERIOD_W-1:0] pend_nx;
  logic                busy_nx;
  logic [LFSR_W-1:0]   lfsr_nx;

  always_comb begin
    step    = bus.tick & ~tick_r;
    running = (period_act != '0);
    wrap    = step && running && (cnt == period_act - P_ONE);
    cnt_nx  = cnt;
    act_nx  = period_act;
    pend_nx = pending;
    busy_nx = busy;

    if (bus.period_wr) begin
      if (!running) begin
        act_nx = bus.period_in;
        cnt_nx = '0;
      end else begin
        pend_nx = bus.period_in;
        busy_nx = 1'b1;
      end
    end

    // A write landing on the wrap cycle is applied right away
    if (wrap) begin
      cnt_nx  = '0;
      busy_nx = 1'b0;
      if (bus.period_wr) begin
        act_nx = bus.period_in;
      end else if (busy) begin
        act_nx = pending;
      end
    end else if (step && running) begin
      cnt_nx = cnt + P_ONE;
    end

    lfsr_nx = wrap ? lfsr_next(lfsr_q) : lfsr_q;
  end

  tone_osc_lfsr15 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .adv   (wrap),
    .state (lfsr_q)
  );

  // Waveform level, judged on the values the counters are about to take
  logic [PERIOD_W:0]   sq_thr;
  logic [PERIOD_W-1:0] pu_raw;
  logic [PERIOD_W-1:0] pu_thr;
  logic                h;

  always_comb begin
    sq_thr = ({1'b0, act_nx} + T_ONE) >> 1;
    pu_raw = act_nx >> 2;
    pu_thr = (pu_raw == '0) ? P_ONE : pu_raw;
    unique case (bus.wave_sel)
      WAVE_SQUARE: h = ({1'b0, cnt_nx} < sq_thr);
      WAVE_PULSE:  h = (cnt_nx < pu_thr);
      WAVE_NOISE:  h = lfsr_nx[0];
      default:     h = 1'b0;
    endcase
  end

  logic [OUT_W-1:0] lvl_hi;
  logic [OUT_W-1:0] lvl_lo;
  logic             sounding;

`ifdef TONE_OSC_VOLUME_EN
  logic [OUT_W-1:0] swing;
  always_comb begin
    swing  = OUT_W'({bus.vol, 7'b0});
    lvl_hi = MID + swing;
    lvl_lo = MID - swing;
  end
`else
  always_comb begin
    lvl_hi = '1;
    lvl_lo = '0;
  end
`endif

  assign sounding = bus.gate && (bus.wave_sel != WAVE_OFF) && (act_nx != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_r          <= 1'b0;
      cnt             <= '0;
      period_act      <= '0;
      pending         <= '0;
      busy            <= 1'b0;
      bus.cycle_start <= 1'b0;
      bus.out         <= MID;
    end else begin
      tick_r          <= bus.tick;
      cnt             <= cnt_nx;
      period_act      <= act_nx;
      pending         <= pend_nx;
      busy            <= busy_nx;
      bus.cycle_start <= wrap;
      bus.out         <= sounding ? (h ? lvl_hi : lvl_lo) : MID;
    end
  end

  assign bus.period_busy = busy;

endmodule

// File: tb/tb_tone_osc.sv
// Bench for tone_osc: directed scenarios then random traffic, checked against an integer model.
// Honours TONE_OSC_VOLUME_EN when the design is built with it.
module tb_tone_osc;
  import tone_osc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tone_osc_if bus ();
  tone_osc dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // behavioural reference state
  int m_tick_r, m_cnt, m_per, m_pend, m_busy, m_lfsr, m_cs, m_out;
  int cur_ws = 0;
  int cur_gate = 1;
  int cur_vol = 15;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int level_high(int ws, int c, int p, int l);
    case (ws)
      0: return (2 * c < p) ? 1 : 0;
      1: return (p < 4) ? ((c == 0) ? 1 : 0) : ((p >= 4 * c + 4) ? 1 : 0);
      2: return l & 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_clock(bit tk, bit wr, int pin, int ws, bit g, bit r);
    bit st, wrap;
    int hi, lo;
    if (r) begin
      m_tick_r = 0; m_cnt = 0; m_per = 0; m_pend = 0; m_busy = 0;
      m_lfsr = 1; m_cs = 0; m_out = 'h800;
      return;
    end
    st   = tk && (m_tick_r == 0);
    wrap = st && (m_per != 0) && (m_cnt + 1 == m_per);
    m_cs = wrap ? 1 : 0;
    if (wrap) begin
      m_cnt  = 0;
      m_lfsr = ((m_lfsr << 1) & 'h7fff) | (((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1);
      if (wr) m_per = pin;
      else if (m_busy != 0) m_per = m_pend;
      m_busy = 0;
    end else begin
      if (st && m_per != 0) m_cnt++;
      if (wr) begin
        if (m_per == 0) begin m_per = pin; m_cnt = 0; end
        else begin m_pend = pin; m_busy = 1; end
      end
    end
    m_tick_r = tk;
`ifdef TONE_OSC_VOLUME_EN
    hi = 'h800 + cur_vol * 128;
    lo = 'h800 - cur_vol * 128;
`else
    hi = 'hfff;
    lo = 0;
`endif
    if (g && ws != 3 && m_per != 0)
      m_out = level_high(ws, m_cnt, m_per, m_lfsr) ? hi : lo;
    else
      m_out = 'h800;
  endtask

  task automatic cyc(bit tk, bit wr, int pin, bit r);
    bus.tick      = tk;
    bus.period_wr = wr;
    bus.period_in = pin[7:0];
    bus.wave_sel  = cur_ws[1:0];
    bus.gate      = cur_gate[0];
`ifdef TONE_OSC_VOLUME_EN
    bus.vol       = cur_vol[3:0];
`endif
    rst           = r;
    @(posedge clk);
    model_clock(tk, wr, pin & 'hff, cur_ws, cur_gate[0], r);
    #1;
    chk("out", 32'(bus.out), m_out);
    chk("cycle_start", 32'(bus.cycle_start), m_cs);
    chk("period_busy", 32'(bus.period_busy), m_busy);
    chk("cnt", 32'(dut.cnt), m_cnt);
    chk("lfsr", 32'(dut.lfsr_q), m_lfsr);
  endtask

  task automatic strobe();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  task automatic write_period(int p);
    cyc(0, 1, p, 0);
  endtask

  initial begin
    // reset with tick toggling
    cyc(1, 0, 0, 1);
    cyc(0, 1, 5, 1);
    cyc(0, 0, 0, 0);
    chk("reset_out", 32'(bus.out), 32'(MIDSCALE));

    // square, period 4, strobe every 3 clks
    cur_ws = 0; cur_gate = 1;
    write_period(4);
    for (int i = 0; i < 16; i++) strobe();

    // tick held high counts once
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);

    // period change from 4 to 6 written at cnt 1
    for (int i = 0; i < 8 && m_cnt != 1; i++) strobe();
    write_period(6);
    for (int i = 0; i < 16; i++) strobe();

    // write coinciding with a wrap
    for (int i = 0; i < 8 && m_cnt != 5; i++) strobe();
    cyc(1, 1, 3, 0);
    for (int i = 0; i < 8; i++) strobe();

    // noise at period 1 from a fresh seed
    cyc(0, 0, 0, 1);
    cur_ws = 2;
    write_period(1);
    for (int i = 0; i < 18; i++) strobe();

    // pulse shape, then gate off while counting
    cur_ws = 1;
    cyc(0, 0, 0, 1);
    write_period(9);
    for (int i = 0; i < 20; i++) strobe();
    cur_gate = 0;
    for (int i = 0; i < 12; i++) strobe();
    cur_gate = 1;

    // writing 0 while running silences at the next wrap
    cur_ws = 0;
    write_period(0);
    for (int i = 0; i < 12; i++) strobe();

    // reset mid-cycle with tick and write active
    write_period(4);
    for (int i = 0; i < 8 && m_cnt != 2; i++) strobe();
    cyc(1, 1, 7, 1);
    cyc(0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit tk, wr, r;
      int pin;
      if ($urandom_range(0, 99) == 0) cur_ws = $urandom_range(0, 3);
      if ($urandom_range(0, 99) == 0) cur_gate = ($urandom_range(0, 9) != 0);
`ifdef TONE_OSC_VOLUME_EN
      if ($urandom_range(0, 99) == 0) cur_vol = $urandom_range(0, 15);
`endif
      tk  = ($urandom_range(0, 2) == 0);
      wr  = ($urandom_range(0, 39) == 0);
      pin = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
      r   = ($urandom_range(0, 499) == 0);
      cyc(tk, wr, pin, r);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
